// File: rtl/spmv_mem_pkg.sv
// spmv_mem_pkg: shared constants, request-entry type and tag helper for the SpMV memory arbiter
package spmv_mem_pkg;
    localparam int DATA_W        = 64;
    localparam int ADDR_W        = 48;
    localparam int KIND_W        = 2;
    localparam int TAG_CACHE_BIT = 0;
    localparam int TAG_DEC_LSB   = 1;
    localparam int REQ_ST        = 0;
    localparam int REQ_CL        = 1;
    localparam int REQ_DL        = 2;
    localparam int N_REQ         = 3;

    typedef enum logic [KIND_W-1:0] {K_NONE = 2'b00, K_ST = 2'b01, K_LD = 2'b10} kind_t;

    typedef struct packed {
        kind_t              kind;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // Load tag: cache loads mark bit 0, decoder loads carry their stream tag above it
    function automatic logic [DATA_W-1:0] ld_tag(input logic from_cache, input logic [1:0] dtag);
        logic [DATA_W-1:0] t;
        t = '0;
        if (from_cache) t[TAG_CACHE_BIT] = 1'b1;
        else t[TAG_DEC_LSB +: 2] = dtag;
        return t;
    endfunction
endpackage

// File: rtl/spmv_mem_arbiter_if.sv
// spmv_mem_arbiter_if: requester, config and memory-port signals of the SpMV memory arbiter
interface spmv_mem_arbiter_if;
    import spmv_mem_pkg::*;
    logic              cfg_ld;
    logic [ADDR_W-1:0] cfg_st_base;
    logic [ADDR_W-1:0] cfg_st_end;
    logic              st_valid;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              cl_valid;
    logic [ADDR_W-1:0] cl_addr;
    logic              cl_ready;
    logic              dl_valid;
    logic [ADDR_W-1:0] dl_addr;
    logic [1:0]        dl_tag;
    logic              dl_ready;
    logic              req_mem_ld;
    logic              req_mem_st;
    logic [ADDR_W-1:0] req_mem_addr;
    logic [DATA_W-1:0] req_mem_d_or_tag;
    logic              req_mem_stall;
    logic              rsp_mem_push;
    logic              idle;
    logic              st_overflow;

    modport master (
        output cfg_ld, cfg_st_base, cfg_st_end, st_valid, st_data, cl_valid, cl_addr,
               dl_valid, dl_addr, dl_tag, req_mem_stall, rsp_mem_push,
        input  st_ready, cl_ready, dl_ready, req_mem_ld, req_mem_st, req_mem_addr,
               req_mem_d_or_tag, idle, st_overflow
    );

    modport slave (
        input  cfg_ld, cfg_st_base, cfg_st_end, st_valid, st_data, cl_valid, cl_addr,
               dl_valid, dl_addr, dl_tag, req_mem_stall, rsp_mem_push,
        output st_ready, cl_ready, dl_ready, req_mem_ld, req_mem_st, req_mem_addr,
               req_mem_d_or_tag, idle, st_overflow
    );
endinterface

// File: rtl/spmv_req_queue.sv
// spmv_req_queue: synchronous FIFO with zero-latency head read and occupancy count
module spmv_req_queue #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk)
        if (i_push) r_mem[r_wp] <= i_din;

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end

    assign o_dout  = r_mem[r_rp];
    assign o_count = r_count;
    assign o_empty = r_count == '0;
endmodule

// File: rtl/spmv_mem_arbiter.sv
// spmv_mem_arbiter: schedules MAC stores, cache loads and decoder loads onto one PE memory port
module spmv_mem_arbiter
    import spmv_mem_pkg::*;
#(
    parameter int QDEPTH          = 16,
    parameter int MAX_OUTSTANDING = 32,
    parameter int STARVE_LIMIT    = 15,
    parameter int ADDR_STEP       = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    spmv_mem_arbiter_if.slave   bus
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int LW = OW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]     w_count;
    logic              w_empty;
    req_t              w_head;
    req_t              w_din;
    logic              w_push;
    logic              w_pop;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_space;
    logic              w_credit;
    logic              w_st_ok;
    logic              w_cl_ok;
    logic              w_dl_ok;
    logic              w_force;
    logic              w_st_win;
    logic              w_ld_push;
    logic              w_ld_pop;
    logic [LW-1:0]     w_inflight;

    logic [OW-1:0]     r_out;
    logic [OW-1:0]     r_qld;
    logic [SW-1:0]     r_starve;
    logic [ADDR_W-1:0] r_st_ptr;
    logic [ADDR_W-1:0] r_st_end;
    logic              r_ovf;
    logic              r_stall;
    logic              r_ld;
    logic              r_st;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Loads already queued, sitting in the output register, or awaiting a response all hold credit
    assign w_inflight = LW'(r_out) + LW'(r_qld) + LW'(r_ld);
    assign w_credit   = w_inflight < LW'(MAX_OUTSTANDING);
    assign w_space    = w_count < CW'(QDEPTH);
    assign w_st_ok    = bus.st_valid && w_space && !bus.cfg_ld;
    assign w_cl_ok    = bus.cl_valid && w_space && w_credit;
    assign w_dl_ok    = bus.dl_valid && w_space && w_credit;
    assign w_force    = (r_starve == SW'(STARVE_LIMIT)) && w_dl_ok;
    assign w_st_win   = r_st_ptr != r_st_end;

    // Single grant: a starved decoder wins, otherwise stores, then cache, then decoder
    always_comb begin
        w_gnt         = '0;
        w_gnt[REQ_ST] = !w_force && w_st_ok;
        w_gnt[REQ_CL] = !w_force && !w_st_ok && w_cl_ok;
        w_gnt[REQ_DL] = w_force || (!w_st_ok && !w_cl_ok && w_dl_ok);
    end

    // Build the queue entry for the granted requester; stores outside the window are dropped
    always_comb begin
        w_din      = '0;
        w_ld_push  = w_gnt[REQ_CL] || w_gnt[REQ_DL];
        w_push     = w_gnt[REQ_ST] ? w_st_win : w_ld_push;
        w_din.kind = w_gnt[REQ_ST] ? K_ST : K_LD;
        w_din.addr = w_gnt[REQ_ST] ? r_st_ptr : (w_gnt[REQ_CL] ? bus.cl_addr : bus.dl_addr);
        w_din.data = w_gnt[REQ_ST] ? bus.st_data : ld_tag(w_gnt[REQ_CL], bus.dl_tag);
    end

    assign w_pop    = !w_empty && !r_stall;
    assign w_ld_pop = w_pop && (w_head.kind == K_LD);

    spmv_req_queue #(.DEPTH(QDEPTH), .W(REQ_W)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Store window pointer and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_st_ptr <= '0;
            r_st_end <= '0;
            r_ovf    <= 1'b0;
        end else if (bus.cfg_ld) begin
            r_st_ptr <= bus.cfg_st_base;
            r_st_end <= bus.cfg_st_end;
            r_ovf    <= 1'b0;
        end else if (w_gnt[REQ_ST]) begin
            r_st_ptr <= w_st_win ? r_st_ptr + ADDR_W'(ADDR_STEP) : r_st_ptr;
            r_ovf    <= r_ovf || !w_st_win;
        end

    // Decoder starvation counter, saturating at the force threshold
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_starve <= '0;
        else r_starve <= (bus.dl_valid && !w_gnt[REQ_DL]) ?
                         ((r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + 1'b1) : '0;

    // Registered stall and memory-port request outputs driven from the popped entry
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_stall <= 1'b0;
            r_ld    <= 1'b0;
            r_st    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_stall <= bus.req_mem_stall;
            r_ld    <= w_ld_pop;
            r_st    <= w_pop && (w_head.kind == K_ST);
            if (w_pop) begin
                r_addr <= w_head.addr;
                r_data <= w_head.data;
            end
        end

    // Queued-load and outstanding-load counters; a response with nothing outstanding is dropped
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_qld <= '0;
            r_out <= '0;
        end else begin
            r_qld <= r_qld + OW'(w_ld_push) - OW'(w_ld_pop);
            if (r_ld && !bus.rsp_mem_push) r_out <= r_out + 1'b1;
            else if (!r_ld && bus.rsp_mem_push && r_out != '0) r_out <= r_out - 1'b1;
        end

    assign bus.st_ready         = w_gnt[REQ_ST];
    assign bus.cl_ready         = w_gnt[REQ_CL];
    assign bus.dl_ready         = w_gnt[REQ_DL];
    assign bus.req_mem_ld       = r_ld;
    assign bus.req_mem_st       = r_st;
    assign bus.req_mem_addr     = r_addr;
    assign bus.req_mem_d_or_tag = r_data;
    assign bus.st_overflow      = r_ovf;
    assign bus.idle             = w_empty && (r_out == '0) && !bus.st_valid && !bus.cl_valid &&
                                  !bus.dl_valid && !r_ld && !r_st;
endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// tb_spmv_mem_arbiter: directed checks of windowed stores, starvation, load credit, stall and reset
module tb_spmv_mem_arbiter;
    import spmv_mem_pkg::*;

    typedef struct {
        logic        ld;
        logic [47:0] addr;
        logic [63:0] d;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    ev_t  mq[$];

    spmv_mem_arbiter_if bus();

    spmv_mem_arbiter #(
        .QDEPTH(16), .MAX_OUTSTANDING(32), .STARVE_LIMIT(15), .ADDR_STEP(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every bus pulse with the cycle it was visible in
    always @(negedge clk) begin : mon
        ev_t e;
        if (rst_n && (bus.req_mem_ld || bus.req_mem_st)) begin
            e.ld   = bus.req_mem_ld;
            e.addr = bus.req_mem_addr;
            e.d    = bus.req_mem_d_or_tag;
            e.cyc  = cyc;
            mq.push_back(e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.cfg_ld = 0; bus.cfg_st_base = '0; bus.cfg_st_end = '0;
        bus.st_valid = 0; bus.st_data = '0;
        bus.cl_valid = 0; bus.cl_addr = '0;
        bus.dl_valid = 0; bus.dl_addr = '0; bus.dl_tag = '0;
        bus.req_mem_stall = 0; bus.rsp_mem_push = 0;
    endtask

    task automatic push_rsp(input int k);
        for (int i = 0; i < k; i++) begin
            bus.rsp_mem_push = 1;
            step();
        end
        bus.rsp_mem_push = 0;
    endtask

    initial begin
        int n, g, first, bad, nst, nld, hit;
        logic [47:0] a;
        clear_inputs();
        step(); step();
        chk("rst_idle", 64'(bus.idle), 64'd1);
        chk("rst_ld", 64'(bus.req_mem_ld), 64'd0);
        chk("rst_st", 64'(bus.req_mem_st), 64'd0);
        chk("rst_ovf", 64'(bus.st_overflow), 64'd0);
        chk("rst_ready", 64'({bus.st_ready, bus.cl_ready, bus.dl_ready}), 64'd0);
        rst_n = 1;
        step();
        chk("post_rst_idle", 64'(bus.idle), 64'd1);

        // Store window 0x1000..0x1018 holds three stores
        bus.cfg_ld = 1; bus.cfg_st_base = 48'h1000; bus.cfg_st_end = 48'h1018;
        bus.st_valid = 1; bus.st_data = $realtobits(1.0);
        #1 chk("cfg_st_ready", 64'(bus.st_ready), 64'd0);
        step();
        bus.cfg_ld = 0;
        mq.delete();
        g = cyc;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            bus.st_data = $realtobits(real'(i + 1));
            #1 if (bus.st_ready) n++;
            step();
        end
        bus.st_valid = 0;
        repeat (5) step();
        chk("st_accepted", 64'(n), 64'd4);
        chk("st_bus_count", 64'(mq.size()), 64'd3);
        bad = 0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].ld || mq[i].addr != 48'h1000 + 48'(i * 8) || mq[i].d != $realtobits(real'(i + 1))) bad++;
        chk("st_bus_content", 64'(bad), 64'd0);
        if (mq.size() > 0) chk("st_latency", 64'(mq[0].cyc - g), 64'd2);
        chk("st_overflow_set", 64'(bus.st_overflow), 64'd1);

        // Starvation: decoder forced on the 16th cycle of contention
        bus.cfg_ld = 1; bus.cfg_st_base = 48'h0; bus.cfg_st_end = 48'h10000;
        step();
        bus.cfg_ld = 0;
        chk("cfg_ovf_clear", 64'(bus.st_overflow), 64'd0);
        mq.delete();
        first = -1;
        n = 0;
        bus.st_valid = 1; bus.cl_valid = 1; bus.dl_valid = 1;
        bus.cl_addr = 48'hC000; bus.dl_addr = 48'hD000; bus.dl_tag = 2'b10;
        for (int i = 1; i <= 30 && first < 0; i++) begin
            #1;
            if (bus.cl_ready) n++;
            if (bus.dl_ready) first = i;
            step();
        end
        bus.st_valid = 0; bus.cl_valid = 0; bus.dl_valid = 0;
        repeat (5) step();
        chk("starve_cycle", 64'(first), 64'd16);
        chk("starve_cl_grants", 64'(n), 64'd0);
        nst = 0; nld = 0; bad = 0;
        foreach (mq[i]) begin
            if (mq[i].ld) begin
                nld++;
                if (mq[i].addr != 48'hD000 || mq[i].d != 64'd4) bad++;
            end else begin
                if (mq[i].addr != 48'(nst * 8)) bad++;
                nst++;
            end
        end
        chk("starve_stores", 64'(nst), 64'd15);
        chk("starve_loads", 64'(nld), 64'd1);
        chk("starve_content", 64'(bad), 64'd0);
        push_rsp(1);
        chk("starve_idle", 64'(bus.idle), 64'd1);

        // Load credit: 32 of 33 cache loads issue until a response returns
        mq.delete();
        n = 0;
        for (int i = 0; i < 45; i++) begin
            bus.cl_valid = 1;
            bus.cl_addr = 48'h20000 + 48'(n * 8);
            #1 if (bus.cl_ready) n++;
            step();
        end
        chk("credit_accepted", 64'(n), 64'd32);
        bus.cl_addr = 48'h20000 + 48'(32 * 8);
        #1 chk("credit_block", 64'(bus.cl_ready), 64'd0);
        bad = 0;
        foreach (mq[i]) if (!mq[i].ld || mq[i].d != 64'd1) bad++;
        chk("credit_bus_loads", 64'(mq.size()), 64'd32);
        chk("credit_tags", 64'(bad), 64'd0);
        bus.rsp_mem_push = 1;
        #1 chk("credit_rsp_cycle", 64'(bus.cl_ready), 64'd0);
        step();
        bus.rsp_mem_push = 0;
        #1 chk("credit_reopen", 64'(bus.cl_ready), 64'd1);
        g = cyc;
        step();
        bus.cl_valid = 0;
        repeat (4) step();
        chk("credit_33_count", 64'(mq.size()), 64'd33);
        if (mq.size() == 33) begin
            chk("credit_33_addr", 64'(mq[32].addr), 64'h20100);
            chk("credit_33_tag", mq[32].d, 64'd1);
            chk("credit_33_lat", 64'(mq[32].cyc - g), 64'd2);
        end
        push_rsp(34);
        chk("credit_drain_idle", 64'(bus.idle), 64'd1);

        // Same-cycle issue and response at outstanding 5
        n = 0;
        for (int i = 0; i < 5; i++) begin
            bus.cl_valid = 1;
            bus.cl_addr = 48'h40000 + 48'(i * 8);
            #1 if (bus.cl_ready) n++;
            step();
        end
        bus.cl_valid = 0;
        repeat (4) step();
        chk("same_pre_loads", 64'(n), 64'd5);
        bus.cl_valid = 1; bus.cl_addr = 48'h40100;
        step();
        bus.cl_valid = 0;
        hit = 0;
        for (int i = 0; i < 8 && hit == 0; i++) begin
            step();
            if (bus.req_mem_ld) begin
                hit = 1;
                bus.rsp_mem_push = 1;
                step();
                bus.rsp_mem_push = 0;
            end
        end
        chk("same_issue_seen", 64'(hit), 64'd1);
        push_rsp(4);
        chk("same_four_left_busy", 64'(bus.idle), 64'd0);
        push_rsp(1);
        chk("same_five_idle", 64'(bus.idle), 64'd1);

        // Stall: queue fills to 16, nothing issues, then 16 drain back-to-back
        bus.req_mem_stall = 1;
        step(); step();
        mq.delete();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            bus.cl_valid = 1;
            bus.cl_addr = 48'h30000 + 48'(n * 8);
            #1 if (bus.cl_ready) n++;
            step();
        end
        chk("stall_fill", 64'(n), 64'd16);
        bus.st_valid = 1; bus.dl_valid = 1;
        #1 chk("stall_full_ready", 64'({bus.st_ready, bus.cl_ready, bus.dl_ready}), 64'd0);
        step();
        bus.st_valid = 0; bus.cl_valid = 0; bus.dl_valid = 0;
        chk("stall_quiet", 64'(mq.size()), 64'd0);
        bus.req_mem_stall = 0;
        repeat (22) step();
        chk("stall_drain_count", 64'(mq.size()), 64'd16);
        bad = 0;
        foreach (mq[i]) begin
            a = 48'h30000 + 48'(i * 8);
            if (!mq[i].ld || mq[i].addr != a || (i > 0 && mq[i].cyc != mq[i-1].cyc + 1)) bad++;
        end
        chk("stall_drain_order", 64'(bad), 64'd0);
        push_rsp(16);
        chk("stall_idle", 64'(bus.idle), 64'd1);

        // Reset in the middle of a burst
        bus.req_mem_stall = 1;
        step(); step();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            bus.cl_valid = 1;
            bus.cl_addr = 48'h50000 + 48'(i * 8);
            #1 if (bus.cl_ready) n++;
            step();
        end
        bus.cl_valid = 0;
        chk("rst_burst_queued", 64'(n), 64'd8);
        bus.req_mem_stall = 0;
        hit = 0;
        for (int i = 0; i < 8 && hit == 0; i++) begin
            step();
            if (bus.req_mem_ld) hit = 1;
        end
        chk("rst_burst_started", 64'(hit), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_ld", 64'(bus.req_mem_ld), 64'd0);
        chk("rst_mid_idle", 64'(bus.idle), 64'd1);
        step(); step();
        rst_n = 1;
        mq.delete();
        repeat (12) step();
        chk("rst_no_stale", 64'(mq.size()), 64'd0);
        chk("rst_after_idle", 64'(bus.idle), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spmv_mem_arbiter.md
Name: spmv_mem_arbiter

Overview:
Memory-request scheduler for one SpMV processing element. It shares the single PE memory port between three requesters:
- the MAC result stream (stores),
- the x-vector cache (loads),
- the sparse-matrix decoder (loads).

It generates store addresses from a configured window, encodes response tags, bounds outstanding loads, and buffers requests against the registered memory-port stall. It replaces ad-hoc pop logic between the request FIFOs and the port.

Parameters:
QDEPTH, 16, output request queue depth (power of 2, >=4)
MAX_OUTSTANDING, 32, maximum loads issued without a response
STARVE_LIMIT, 15, cycles a pending decoder load may be bypassed before it is forced
ADDR_STEP, 8, store address increment in bytes

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_ld  in  1  load store window (one-cycle pulse)
cfg_st_base  in  48  first store address
cfg_st_end  in  48  exclusive end of store window
st_valid  in  1  MAC result available
st_data  in  64  MAC result value
st_ready  out  1  store accepted this cycle
cl_valid  in  1  cache load request
cl_addr  in  48  cache load address
cl_ready  out  1  cache load accepted
dl_valid  in  1  decoder load request
dl_addr  in  48  decoder load address
dl_tag  in  2  decoder stream tag
dl_ready  out  1  decoder load accepted
req_mem_ld  out  1  load issue
req_mem_st  out  1  store issue
req_mem_addr  out  48  request address
req_mem_d_or_tag  out  64  store data or load tag
req_mem_stall  in  1  memory port stall
rsp_mem_push  in  1  load response returned
idle  out  1  nothing queued, outstanding or pending
st_overflow  out  1  sticky: store arrived with window exhausted

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0 except idle=1.
  - Queue empty; outstanding=0; starve count 0; st_ptr=0, st_end=0.
  - A mid-operation reset discards queued requests; no bus pulse is emitted after reset asserts.
- Config: on cfg_ld, st_ptr<=cfg_st_base and st_end<=cfg_st_end; st_overflow clears. st_ready=0 in a cfg_ld cycle.
- Acceptance: at most one grant per cycle. Grant requires queue count < QDEPTH (count before this cycle's pop).
- Load credit: a load may be granted only if outstanding + queued loads < MAX_OUTSTANDING.
- Priority order:
  - Forced decoder grant when starve count == STARVE_LIMIT and dl is eligible.
  - Otherwise st > cl > dl.
- Starve counter:
  - Increments each cycle dl_valid is high and not granted (saturates).
  - Clears on a dl grant or when dl_valid is low.
- ready outputs: combinational, one-hot or zero; a transfer happens when valid && ready.
- Store grant:
  - If st_ptr != st_end: enqueue store (addr=st_ptr, data=st_data), then st_ptr += ADDR_STEP, 48-bit wrap.
  - Else: the value is consumed but not enqueued, and st_overflow is set.
- Load tag encoding, other d_or_tag bits 0:
  - cache: d_or_tag[0]=1.
  - decoder: d_or_tag[0]=0, [2:1]=dl_tag.
- Queue write happens on the grant edge. stall_r = req_mem_stall registered one cycle.
- Pop when queue non-empty and !stall_r. Outputs are registered from the popped entry; ld/st are 0 in any cycle without a pop.
- Minimum latency: grant in cycle t, request on the bus in cycle t+2.
- Outstanding counter:
  - +1 on req_mem_ld issue; -1 on rsp_mem_push; unchanged if both occur in one cycle.
  - A response arriving at outstanding=0 is ignored and the counter does not underflow.
- Full queue: all ready=0. Pop and grant in the same cycle are allowed; count is unchanged.
- idle = queue empty && outstanding==0 && !st_valid && !cl_valid && !dl_valid && no bus pulse this cycle.

Decomposition:
- Shared package spmv_mem_pkg:
  - tag bit positions (TAG_CACHE_BIT=0, TAG_DEC_LSB=1)
  - request-entry field widths (64+48+2)
  - requester index constants
- Sub-module: spmv_req_queue, a synchronous FIFO with count output, async active-low reset, and zero read latency.

Test Plan:
- cfg base=0x1000, end=0x1018; 4 stores 1.0..4.0 → bus stores at 0x1000/0x1008/0x1010; 4th consumed, not issued; st_overflow=1.
- st, cl, dl all valid continuously with st_valid held → dl_ready asserts exactly on the 16th cycle (STARVE_LIMIT=15); tag[2:1] equals dl_tag.
- 33 cache loads, no responses → 32 issued; cl_ready low; one rsp_mem_push → 33rd issued on the bus 2+ cycles later with d_or_tag=1.
- req_mem_stall held 20 cycles with streaming loads → queue fills to 16, all ready=0, no bus activity; on stall release, 16 requests issue in order, back-to-back.
- rst_n low mid-burst with queue at 8 → outputs drop immediately; after release idle=1; no stale request issued.
- Same-cycle ld issue and rsp_mem_push at outstanding=5 → counter stays 5.
